// File: rtl/t_toggle_seq.sv
// Toggle-command sequencer: emits a burst of prescaled single-cycle t strobes for a downstream T flip-flop.
// Optional continuous mode (burst_len==0 runs until stop) is enabled by defining TOGGLE_SEQ_CONTINUOUS_EN.
module t_toggle_seq #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div_val,
    input  logic [CNT_W-1:0] burst_len,
    output logic             t,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

`ifdef TOGGLE_SEQ_CONTINUOUS_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    logic [1:0]       state,     state_nxt;
    logic [DIV_W-1:0] presc,     presc_nxt;
    logic [DIV_W-1:0] div_q,     div_nxt;
    logic [CNT_W-1:0] len_q,     len_nxt;
    logic             cont_q,    cont_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             t_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [DIV_W-1:0] start_div;

    // A zero divide value behaves as divide-by-one.
    assign start_div = (div_val == '0) ? DIV_W'(1) : div_val;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state     <= ST_IDLE;
            presc     <= '0;
            div_q     <= '0;
            len_q     <= '0;
            cont_q    <= 1'b0;
            pulse_cnt <= '0;
            t         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            div_q     <= div_nxt;
            len_q     <= len_nxt;
            cont_q    <= cont_nxt;
            pulse_cnt <= cnt_nxt;
            t         <= t_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        div_nxt   = div_q;
        len_nxt   = len_q;
        cont_nxt  = cont_q;
        cnt_nxt   = pulse_cnt;
        t_nxt     = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    div_nxt   = start_div;
                    len_nxt   = burst_len;
                    cont_nxt  = CONT_EN && (burst_len == '0);
                    cnt_nxt   = '0;
                    presc_nxt = start_div - DIV_W'(1);
                    if ((burst_len != '0) || CONT_EN) begin
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            ST_RUN: begin
                // Abort wins over a strobe due on the same edge.
                if (stop) begin
                    state_nxt = ST_FIN;
                end else if (presc != '0) begin
                    presc_nxt = presc - DIV_W'(1);
                end else begin
                    t_nxt     = 1'b1;
                    cnt_nxt   = pulse_cnt + CNT_W'(1);
                    presc_nxt = div_q - DIV_W'(1);
                    if (!cont_q && (cnt_nxt == len_q)) begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ST_RUN);
    end

endmodule

// File: doc/t_toggle_seq.md
Name: t_toggle_seq

Overview:
- Programmable toggle-command sequencer that drives the t input of the synchronous T flip-flop stage directly downstream.
- On a start request it emits a burst of single-cycle t strobes, evenly spaced by a clock prescaler.
- Reports busy/done status and a running strobe count to the control logic.

Parameters:
- DIV_W, 8, width of the prescaler divide value
- CNT_W, 8, width of the burst length and strobe counter

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- sync_reset  input  1  synchronous, active-high reset; sampled on rising clk edge; overrides every other input
- start  input  1  start request; sampled on rising clk edge; accepted only in IDLE
- stop  input  1  abort request; sampled on rising clk edge; acts only in RUN
- div_val  input  DIV_W  strobe spacing in clk cycles; latched when start is accepted; 0 is treated as 1
- burst_len  input  CNT_W  number of t strobes per burst; latched when start is accepted
- t  output  1  registered toggle strobe to the T flip-flop stage
- busy  output  1  high while a burst is in progress (state RUN)
- done  output  1  one-cycle pulse when a burst ends, either completed or aborted
- pulse_cnt  output  CNT_W  strobes issued since the last accepted start; holds its value after the burst ends

Behaviour:
- Reset (sync_reset=1 at an edge):
  - t=0, busy=0, done=0, pulse_cnt=0
  - prescaler=0, latched div/len=0, state=IDLE
  - Reset asserted mid-burst aborts immediately; no done pulse.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, RUN, FIN.
- IDLE:
  - t=0, busy=0.
  - start=1 at edge k:
    - latch div_q = max(div_val,1) and len_q = burst_len
    - clear pulse_cnt to 0
    - load prescaler with div_q-1
  - If len_q≠0, enter RUN with busy=1 from edge k.
  - If len_q==0, enter FIN with no strobes.
  - stop is ignored in IDLE.
- RUN:
  - Each edge with prescaler≠0: decrement prescaler, t=0.
  - Edge with prescaler==0:
    - t=1 for exactly one cycle
    - pulse_cnt+1
    - reload prescaler with div_q-1
  - The first strobe is registered at edge k+div_q; later strobes follow every div_q edges.
  - With div_q=1, t stays high for len_q consecutive cycles.
  - At the edge that registers strobe number len_q, state goes to FIN.
  - start is ignored in RUN; changes to div_val and burst_len are ignored until the next accepted start.
- stop=1 in RUN:
  - At that edge: t=0, busy=0, state goes to FIN, pulse_cnt holds.
  - stop has priority over a strobe due at the same edge; that strobe is not issued.
- FIN:
  - One cycle with t=0, busy=0, done=1.
  - Then return to IDLE; done drops at the next edge.
  - start in FIN is ignored. The earliest accepted restart is the first edge in IDLE.
- Widths and wrap:
  - The prescaler is DIV_W bits.
  - pulse_cnt never exceeds len_q, so it never wraps (see Optional Feature for the exception).
  - burst_len = 2^CNT_W-1 is a legal maximum.
- Total burst duration (start edge to done rise): div_q*len_q + 1 edges.

Optional Feature:
- Macro: TOGGLE_SEQ_CONTINUOUS_EN
- Defined:
  - burst_len==0 at start selects continuous mode.
  - RUN issues strobes every div_q cycles indefinitely.
  - pulse_cnt wraps modulo 2^CNT_W.
  - Only stop or sync_reset ends the burst; stop ends it with the normal FIN/done sequence.
- Undefined:
  - burst_len==0 produces no strobes; the block goes directly IDLE→FIN→IDLE (done=1 one cycle after the start edge).
  - No continuous mode exists.

Test Plan:
- Reset then idle: sync_reset=1 for 2 cycles, then 10 idle cycles → t=0, busy=0, done=0, pulse_cnt=0 throughout.
- Normal burst: div_val=3, burst_len=4, start pulse at edge k →
  - t=1 for one cycle after edges k+3, k+6, k+9, k+12
  - busy=1 over edges k..k+12
  - done=1 after edge k+13
  - pulse_cnt ends at 4
- Back-to-back strobes: div_val=0 (treated as 1), burst_len=5 → t high for 5 consecutive cycles starting after edge k+1, done one cycle later, pulse_cnt=5.
- Abort: div_val=4, burst_len=10, stop=1 at edge k+8, coinciding with the 2nd strobe → only 1 strobe issued, busy drops at k+8, done=1 after k+9, pulse_cnt=1.
- Ignored inputs: during a burst, pulse start and change div_val to 7 → spacing stays at the latched value and no restart occurs. Then apply sync_reset mid-burst → all outputs 0 next cycle, no done.
- burst_len=0:
  - Without TOGGLE_SEQ_CONTINUOUS_EN → no strobes, done after k+1.
  - With the macro and div_val=2 → strobes every 2 cycles until stop, then done pulse.
